// File: rtl/grf_sb_if.sv
// grf_sb_if: register file port bundle between D/W stages and the scoreboarded GRF
interface grf_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] ra;
  logic [NUM_RD*DATA_W-1:0] rd;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_ready;
  logic                     we;
  logic [ADDR_W-1:0]        wa;
  logic [DATA_W-1:0]        wd;
  logic [31:0]              pc;
  logic                     sb_err;
  modport master (
    output ra, iss_en, iss_addr, we, wa, wd, pc,
    input  rd, rd_busy, iss_ready, sb_err
  );
  modport slave (
    input  ra, iss_en, iss_addr, we, wa, wd, pc,
    output rd, rd_busy, iss_ready, sb_err
  );
endinterface

// File: rtl/grf_sb.sv
// grf_sb: multi-port register file with write-first bypass and per-register in-flight scoreboard
module grf_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2,
  parameter bit TRACE  = 1
) (
  input logic     clk,
  input logic     reset,
  grf_sb_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;
  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  cnt  [NREG];
  logic [ADDR_W-1:0] a    [NUM_RD];
  logic              err;
  logic              iss_ready;
  logic              iss_ok;
  logic              wr_ok;
  assign iss_ready     = cnt[bus.iss_addr] != '1;
  assign iss_ok        = bus.iss_en && bus.iss_addr != '0 && iss_ready;
  assign wr_ok         = bus.we && bus.wa != '0;
  assign bus.iss_ready = iss_ready;
  assign bus.sb_err    = err;
  // read ports: $0 is hardwired zero, a same-cycle write wins over the stored value
  always_comb begin
    bus.rd      = '0;
    bus.rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      a[i] = bus.ra[i*ADDR_W +: ADDR_W];
      bus.rd[i*DATA_W +: DATA_W] = a[i] == '0 ? '0 : (bus.we && bus.wa == a[i]) ? bus.wd : regs[a[i]];
      bus.rd_busy[i] = a[i] != '0 && cnt[a[i]] != '0 && !(bus.we && bus.wa == a[i] && cnt[a[i]] == CNT_W'(1));
    end
  end
  // register storage; $0 is only ever cleared
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else if (wr_ok) begin
      regs[bus.wa] <= bus.wd;
    end
  end
  // in-flight counters: issue increments, retire decrements, underflow/overflow flag a sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) cnt[r] <= '0;
      err <= 1'b0;
    end else begin
      for (int r = 1; r < NREG; r++)
        cnt[r] <= cnt[r] + CNT_W'(iss_ok && bus.iss_addr == ADDR_W'(r))
                         - CNT_W'(bus.we && bus.wa == ADDR_W'(r) && cnt[r] != '0);
      if ((wr_ok && cnt[bus.wa] == '0) || (bus.iss_en && !iss_ready)) err <= 1'b1;
    end
  end
  // simulation trace of every committed write
  if (TRACE) begin : g_trace
    always @(posedge clk) begin
      if (!reset && wr_ok) $display("@%08h: $%d <= %08h", bus.pc, bus.wa, bus.wd);
    end
  end
endmodule

// File: tb/tb_grf_sb.sv
// tb_grf_sb: directed scoreboard bench for the three-port register file
module tb_grf_sb;
  logic clk = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;
  typedef struct {
    string       tag;
    logic [95:0] v;
  } item_t;
  item_t q[$];
  grf_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3)) bus ();
  grf_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(3), .CNT_W(2), .TRACE(1)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [14:0] a3(input int a2, input int a1, input int a0);
    return {5'(a2), 5'(a1), 5'(a0)};
  endfunction
  function automatic logic [95:0] r3(input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0);
    return {d2, d1, d0};
  endfunction
  task automatic drv(input logic [14:0] ra, input logic ie, input int ia, input logic w, input int wa, input logic [31:0] wd);
    @(negedge clk);
    bus.ra       = ra;
    bus.iss_en   = ie;
    bus.iss_addr = 5'(ia);
    bus.we       = w;
    bus.wa       = 5'(wa);
    bus.wd       = wd;
  endtask
  task automatic push(input string tag, input logic [95:0] v);
    item_t e;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask
  task automatic pop_chk(input logic [95:0] obs);
    item_t e;
    total++;
    if (q.size() == 0) begin
      $error("FAIL scoreboard: empty queue, got %h", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.v) passed++;
      else $error("FAIL %s: got %h want %h", e.tag, obs, e.v);
    end
  endtask
  task automatic chk4(input string t, input logic [95:0] rde, input logic [2:0] be, input logic re, input logic ee);
    push({t, " rd"}, rde);
    push({t, " rd_busy"}, 96'(be));
    push({t, " iss_ready"}, 96'(re));
    push({t, " sb_err"}, 96'(ee));
    #1;
    pop_chk(bus.rd);
    pop_chk(96'(bus.rd_busy));
    pop_chk(96'(bus.iss_ready));
    pop_chk(96'(bus.sb_err));
  endtask
  initial begin
    reset        = 1'b1;
    bus.ra       = '0;
    bus.iss_en   = 1'b0;
    bus.iss_addr = '0;
    bus.we       = 1'b0;
    bus.wa       = '0;
    bus.wd       = '0;
    bus.pc       = 32'h3000;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      bus.ra       = a3(a, a, a);
      bus.iss_addr = 5'(a);
      chk4("reset", '0, 3'b000, 1'b1, 1'b0);
    end
    drv(a3(0, 0, 0), 1, 5, 0, 0, 0);
    chk4("iss5", '0, 3'b000, 1'b1, 1'b0);
    drv(a3(0, 0, 5), 0, 5, 0, 0, 0);
    chk4("busy5", '0, 3'b001, 1'b1, 1'b0);
    drv(a3(0, 0, 5), 0, 0, 1, 5, 32'h1234ABCD);
    chk4("bypass5", r3(0, 0, 32'h1234ABCD), 3'b000, 1'b1, 1'b0);
    drv(a3(0, 0, 5), 0, 5, 0, 0, 0);
    chk4("post5", r3(0, 0, 32'h1234ABCD), 3'b000, 1'b1, 1'b0);
    drv(a3(0, 0, 0), 1, 0, 1, 0, 32'hFFFFFFFF);
    chk4("wr0", '0, 3'b000, 1'b1, 1'b0);
    drv(a3(0, 0, 0), 0, 0, 0, 0, 0);
    chk4("post0", '0, 3'b000, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      drv(a3(0, 0, 7), 1, 7, 0, 0, 0);
      chk4("iss7", '0, k == 0 ? 3'b000 : 3'b001, 1'b1, 1'b0);
    end
    drv(a3(0, 0, 7), 1, 7, 0, 0, 0);
    chk4("full7", '0, 3'b001, 1'b0, 1'b0);
    drv(a3(0, 0, 7), 0, 7, 0, 0, 0);
    chk4("ovf7", '0, 3'b001, 1'b0, 1'b1);
    drv(a3(0, 0, 7), 0, 7, 1, 7, 32'h77);
    chk4("ret7a", r3(0, 0, 32'h77), 3'b001, 1'b0, 1'b1);
    drv(a3(0, 0, 7), 1, 7, 1, 7, 32'h78);
    chk4("issret7", r3(0, 0, 32'h78), 3'b001, 1'b1, 1'b1);
    drv(a3(0, 0, 7), 0, 7, 1, 7, 32'h79);
    chk4("ret7b", r3(0, 0, 32'h79), 3'b001, 1'b1, 1'b1);
    drv(a3(0, 0, 7), 0, 7, 1, 7, 32'h7A);
    chk4("ret7c", r3(0, 0, 32'h7A), 3'b000, 1'b1, 1'b1);
    drv(a3(0, 0, 7), 0, 7, 0, 0, 0);
    chk4("idle7", r3(0, 0, 32'h7A), 3'b000, 1'b1, 1'b1);
    reset = 1'b1;
    drv(a3(0, 0, 7), 0, 7, 0, 0, 0);
    reset = 1'b0;
    chk4("rst7", '0, 3'b000, 1'b1, 1'b0);
    drv(a3(0, 0, 9), 0, 9, 1, 9, 32'hCAFEF00D);
    chk4("wr9", r3(0, 0, 32'hCAFEF00D), 3'b000, 1'b1, 1'b0);
    drv(a3(0, 0, 9), 0, 9, 0, 0, 0);
    chk4("unf9", r3(0, 0, 32'hCAFEF00D), 3'b000, 1'b1, 1'b1);
    drv(a3(0, 0, 9), 1, 9, 1, 9, 32'h11111111);
    reset = 1'b1;
    chk4("rstwr9", r3(0, 0, 32'h11111111), 3'b000, 1'b1, 1'b1);
    drv(a3(0, 0, 9), 0, 9, 0, 0, 0);
    reset = 1'b0;
    chk4("rst9", '0, 3'b000, 1'b1, 1'b0);
    drv(a3(0, 0, 0), 1, 4, 0, 0, 0);
    drv(a3(0, 0, 0), 0, 0, 1, 4, 32'h44444444);
    drv(a3(4, 3, 3), 0, 0, 1, 3, 32'h33);
    chk4("3port", r3(32'h44444444, 32'h33, 32'h33), 3'b000, 1'b1, 1'b0);
    drv(a3(4, 3, 3), 0, 0, 0, 0, 0);
    chk4("3post", r3(32'h44444444, 32'h33, 32'h33), 3'b000, 1'b1, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/grf_sb.md
Name: grf_sb

Overview:
- Parametrised general register file for the pipelined MIPS core; the next generation of the single-cycle register file.
- Adds N read ports, same-cycle write-to-read bypass, and a per-register in-flight scoreboard.
- Sits in D stage: read ports feed the operand path; issue comes from D; the write port comes from W.
- Per-read-port busy flags drive the hazard/stall unit.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; register count = 2**ADDR_W.
- NUM_RD, 2, number of read ports (1..4).
- CNT_W, 2, width of each scoreboard counter; max in-flight writers per register = 2**CNT_W-1.
- TRACE, 1, when 1, every committed write is printed in simulation.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- ra  in  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W].
- rd  out  NUM_RD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  port i's register has an outstanding writer not retiring this cycle.
- iss_en  in  1  D stage issues an instruction that will write iss_addr.
- iss_addr  in  ADDR_W  destination of the issuing instruction.
- iss_ready  out  1  iss_addr's counter is below max.
- we  in  1  W-stage write enable.
- wa  in  ADDR_W  write address.
- wd  in  DATA_W  write data.
- pc  in  32  PC of the writing instruction, used for the trace only.
- sb_err  out  1  sticky scoreboard protocol error flag.

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - all registers and all counters become 0; sb_err becomes 0.
  - reset overrides any we/iss_en in the same cycle.
  - reset mid-flight discards all pending counts.
- Register 0:
  - always reads 0 and is never written; its counter is always 0.
  - we with wa==0 is a no-op: no trace, no counter change.
  - iss_en with iss_addr==0 is ignored and does not set sb_err.
- Read (combinational), for each port i:
  - ra_i==0 → rd_i=0.
  - else if we && wa==ra_i → rd_i=wd (write-first bypass).
  - else rd_i = reg[ra_i].
- Write: on the edge with we && wa!=0 → reg[wa]<=wd.
  - If TRACE=1, display "@%08h: $%d <= %08h" with pc, wa, wd.
- Scoreboard counter cnt[r], updated each edge (r!=0):
  - +1 if accepted issue to r (iss_en && iss_ready && iss_addr==r).
  - -1 if committed write to r and cnt[r]!=0.
  - Both in the same cycle → unchanged.
  - Write with cnt[r]==0 → counter stays 0, write still commits, sb_err<=1.
- iss_ready = (cnt[iss_addr] != 2**CNT_W-1), combinational.
  - iss_en while !iss_ready: issue dropped, counter unchanged, sb_err<=1.
  - The caller must stall instead of issuing.
- rd_busy_i = ra_i!=0 && cnt[ra_i]!=0 && !(we && wa==ra_i && cnt[ra_i]==1).
  - The last writer retiring this cycle is covered by the bypass.
  - Same-cycle issue to ra_i does not affect rd_busy_i; the counter is registered.
- sb_err clears only on reset.
- Latency:
  - read: 0 cycles.
  - write visible to a non-bypassed read: next cycle.
  - counter update visible: next cycle.

Test Plan:
- Reset, then read all 32 addresses on every port → all rd=0, rd_busy=0, iss_ready=1, sb_err=0.
- Issue $5; next cycle ra0=5 → rd_busy[0]=1. Then we, wa=5, wd=0x1234ABCD, pc=0x3000 → same cycle rd0=0x1234ABCD, rd_busy[0]=0; trace prints "@00003000: $ 5 <= 1234abcd"; cnt[5]=0 afterwards.
- we, wa=0, wd=0xFFFFFFFF; also iss_en, iss_addr=0 → rd of $0 stays 0, no trace, sb_err=0.
- Issue $7 three times (CNT_W=2) → iss_ready=0 for $7. A fourth iss_en sets sb_err=1 and cnt stays 3. Issue and write $7 in the same cycle → cnt unchanged.
- Write $9 with cnt=0 → reg[9] updated, sb_err=1, counter stays 0. Then reset with we=1, wa=9 → reg[9]=0, sb_err=0.
- NUM_RD=3: ra={3,3,4} with we, wa=3 → ports 0 and 1 show wd, port 2 shows reg[4].
